// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - bus bundle between pc_sequencer, instruction memory, decoder and next_pc
//
// Purpose: groups every non-clock/reset signal of pc_sequencer.
//   master modport : the sequencer side
//   slave modport  : the environment side (imem, decoder, next_pc, control)
// Signals:
//   start                         level request to leave IDLE/HALT
//   imem_req / imem_addr          fetch request and address (sequencer out)
//   imem_ack                      fetch complete, decode inputs valid
//   dec_jmp/dec_brz/dec_jr/dec_halt decoded control-flow class
//   zero                          ALU zero flag
//   jmx / bmx                     next_pc selects (curPC+imm / Rb)
//   pc_next                       next_pc result
//   cur_pc                        PC register
//   retire / halted / instr_count status
//   step_mode                     only with SINGLE_STEP_EN defined
interface pc_sequencer_if #(
   parameter int PC_W  = 8,
   parameter int CNT_W = 16
);
   logic             start;
   logic             imem_req;
   logic [PC_W-1:0]  imem_addr;
   logic             imem_ack;
   logic             dec_jmp;
   logic             dec_brz;
   logic             dec_jr;
   logic             dec_halt;
   logic             zero;
   logic             jmx;
   logic             bmx;
   logic [PC_W-1:0]  pc_next;
   logic [PC_W-1:0]  cur_pc;
   logic             retire;
   logic             halted;
   logic [CNT_W-1:0] instr_count;
`ifdef SINGLE_STEP_EN
   logic             step_mode;
`endif

   modport master (
      input  start, imem_ack, dec_jmp, dec_brz, dec_jr, dec_halt, zero, pc_next,
`ifdef SINGLE_STEP_EN
      input  step_mode,
`endif
      output imem_req, imem_addr, jmx, bmx, cur_pc, retire, halted, instr_count
   );

   modport slave (
      output start, imem_ack, dec_jmp, dec_brz, dec_jr, dec_halt, zero, pc_next,
`ifdef SINGLE_STEP_EN
      output step_mode,
`endif
      input  imem_req, imem_addr, jmx, bmx, cur_pc, retire, halted, instr_count
   );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/execute controller owning the Redux-V program counter
//
// Purpose: runs IDLE -> FETCH -> EXEC -> (FETCH | HALT), holds the PC, latches the
// decoded control-flow class on imem_ack and steers next_pc during EXEC.
// Optional feature macro: SINGLE_STEP_EN (adds bus.step_mode; every EXEC then halts).
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  pc_sequencer_if.master (see interface file for signal list)
module pc_sequencer #(
   parameter int             PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int             CNT_W    = 16
) (
   input logic              clk,
   input logic              rst,
   pc_sequencer_if.master   bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [PC_W-1:0]  cur_pc_q, cur_pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             jmp_q, jmp_d;
   logic             brz_q, brz_d;
   logic             jr_q, jr_d;
   logic             halt_q, halt_d;
   logic             step_halt;

`ifdef SINGLE_STEP_EN
   assign step_halt = bus.step_mode;
`else
   assign step_halt = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cur_pc_q <= RESET_PC;
         cnt_q    <= '0;
         jmp_q    <= 1'b0;
         brz_q    <= 1'b0;
         jr_q     <= 1'b0;
         halt_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cur_pc_q <= cur_pc_d;
         cnt_q    <= cnt_d;
         jmp_q    <= jmp_d;
         brz_q    <= brz_d;
         jr_q     <= jr_d;
         halt_q   <= halt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cur_pc_d = cur_pc_q;
      cnt_d    = cnt_q;
      jmp_d    = jmp_q;
      brz_d    = brz_q;
      jr_d     = jr_q;
      halt_d   = halt_q;
      bus.imem_req = 1'b0;
      bus.jmx      = 1'b0;
      bus.bmx      = 1'b0;
      bus.retire   = 1'b0;
      bus.halted   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) state_d = S_FETCH;
         end
         S_FETCH: begin
            bus.imem_req = 1'b1;
            if (bus.imem_ack) begin
               jmp_d   = bus.dec_jmp;
               brz_d   = bus.dec_brz;
               jr_d    = bus.dec_jr;
               halt_d  = bus.dec_halt;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            // jr wins outright; jmp beats brz only by both mapping to jmx
            bus.bmx    = jr_q;
            bus.jmx    = !jr_q && (jmp_q || (brz_q && bus.zero));
            bus.retire = 1'b1;
            cur_pc_d   = bus.pc_next;
            cnt_d      = cnt_q + CNT_W'(1);
            state_d    = (halt_q || step_halt) ? S_HALT : S_FETCH;
         end
         S_HALT: begin
            bus.halted = 1'b1;
            if (bus.start) state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.imem_addr   = cur_pc_q;
   assign bus.cur_pc      = cur_pc_q;
   assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] imm;
   logic [7:0] rb;
   int         checks = 0;
   int         errors = 0;

   pc_sequencer_if #(.PC_W(8), .CNT_W(16)) bus ();

   pc_sequencer #(.PC_W(8), .RESET_PC(8'd0), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   // next_pc datapath model
   always_comb begin
      if (bus.bmx)      bus.pc_next = rb;
      else if (bus.jmx) bus.pc_next = bus.cur_pc + imm;
      else              bus.pc_next = bus.cur_pc + 8'd1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge while in FETCH; returns at the negedge after EXEC.
   task automatic do_instr(input logic [7:0] exp_addr, input int delay,
                           input logic jmp, input logic brz, input logic jr,
                           input logic hlt, input logic z,
                           input logic [7:0] i_imm, input logic [7:0] i_rb,
                           input logic exp_jmx, input logic exp_bmx,
                           input logic [7:0] exp_pc, input logic [15:0] exp_cnt);
      check("fetch_req", bus.imem_req, 1'b1);
      check("fetch_addr", bus.imem_addr, exp_addr);
      for (int k = 0; k < delay; k++) begin
         @(posedge clk); @(negedge clk);
         check("stall_req", bus.imem_req, 1'b1);
         check("stall_pc", bus.cur_pc, exp_addr);
      end
      bus.imem_ack = 1'b1;
      bus.dec_jmp  = jmp;
      bus.dec_brz  = brz;
      bus.dec_jr   = jr;
      bus.dec_halt = hlt;
      bus.zero     = z;
      imm          = i_imm;
      rb           = i_rb;
      @(posedge clk); @(negedge clk);
      bus.imem_ack = 1'b0;
      bus.dec_jmp  = 1'b0;
      bus.dec_brz  = 1'b0;
      bus.dec_jr   = 1'b0;
      bus.dec_halt = 1'b0;
      check("exec_retire", bus.retire, 1'b1);
      check("exec_req", bus.imem_req, 1'b0);
      check("exec_jmx", bus.jmx, exp_jmx);
      check("exec_bmx", bus.bmx, exp_bmx);
      @(posedge clk); @(negedge clk);
      bus.zero = 1'b0;
      check("post_pc", bus.cur_pc, exp_pc);
      check("post_cnt", bus.instr_count, exp_cnt);
      check("post_retire", bus.retire, 1'b0);
      check("post_jmx", bus.jmx, 1'b0);
      check("post_bmx", bus.bmx, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      bus.imem_ack = 1'b0;
      bus.dec_jmp = 1'b0;
      bus.dec_brz = 1'b0;
      bus.dec_jr = 1'b0;
      bus.dec_halt = 1'b0;
      bus.zero = 1'b0;
`ifdef SINGLE_STEP_EN
      bus.step_mode = 1'b0;
`endif
      imm = 8'd0;
      rb = 8'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_pc", bus.cur_pc, 8'd0);
      check("rst_cnt", bus.instr_count, 16'd0);
      check("rst_req", bus.imem_req, 1'b0);
      check("rst_halted", bus.halted, 1'b0);
      check("rst_retire", bus.retire, 1'b0);
      check("rst_jmx", bus.jmx, 1'b0);
      check("rst_bmx", bus.bmx, 1'b0);

      rst = 1'b0;
      bus.start = 1'b1;
      @(posedge clk); @(negedge clk);

      // sequential run
      do_instr(8'd0, 1, 0, 0, 0, 0, 0, 8'd0, 8'd0, 0, 0, 8'd1, 16'd1);
      do_instr(8'd1, 1, 0, 0, 0, 0, 0, 8'd0, 8'd0, 0, 0, 8'd2, 16'd2);
      do_instr(8'd2, 1, 0, 0, 0, 0, 0, 8'd0, 8'd0, 0, 0, 8'd3, 16'd3);
      // relative jumps 3 -> 120 -> 126
      do_instr(8'd3, 1, 1, 0, 0, 0, 0, 8'd117, 8'd0, 1, 0, 8'd120, 16'd4);
      do_instr(8'd120, 1, 1, 0, 0, 0, 0, 8'd6, 8'd0, 1, 0, 8'd126, 16'd5);
      // jr + jmp with Rb=55: jr wins
      do_instr(8'd126, 1, 1, 0, 1, 0, 0, 8'd6, 8'd55, 0, 1, 8'd55, 16'd6);
      do_instr(8'd55, 1, 0, 0, 1, 0, 0, 8'd0, 8'd0, 0, 1, 8'd0, 16'd7);
      // brz not taken, then taken with wrap
      do_instr(8'd0, 1, 0, 1, 0, 0, 0, 8'hFC, 8'd0, 0, 0, 8'd1, 16'd8);
      do_instr(8'd1, 1, 0, 0, 1, 0, 0, 8'd0, 8'd0, 0, 1, 8'd0, 16'd9);
      do_instr(8'd0, 1, 0, 1, 0, 0, 1, 8'hFC, 8'd0, 1, 0, 8'd252, 16'd10);
      // 5-cycle stall, then zero-latency ack on the halt at pc 10
      do_instr(8'd252, 5, 0, 0, 1, 0, 0, 8'd0, 8'd10, 0, 1, 8'd10, 16'd11);
      bus.start = 1'b0;
      do_instr(8'd10, 0, 0, 0, 0, 1, 0, 8'd0, 8'd0, 0, 0, 8'd11, 16'd12);
      for (int k = 0; k < 3; k++) begin
         check("halt_halted", bus.halted, 1'b1);
         check("halt_req", bus.imem_req, 1'b0);
         check("halt_pc", bus.cur_pc, 8'd11);
         @(posedge clk); @(negedge clk);
      end
      bus.start = 1'b1;
      @(posedge clk); @(negedge clk);
      check("resume_halted", bus.halted, 1'b0);
      do_instr(8'd11, 1, 0, 0, 1, 0, 0, 8'd0, 8'd40, 0, 1, 8'd40, 16'd13);

      // reset mid-fetch at pc 40
      check("mid_req", bus.imem_req, 1'b1);
      check("mid_addr", bus.imem_addr, 8'd40);
      rst = 1'b1;
      bus.start = 1'b0;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      check("mrst_req", bus.imem_req, 1'b0);
      check("mrst_pc", bus.cur_pc, 8'd0);
      check("mrst_cnt", bus.instr_count, 16'd0);
      bus.imem_ack = 1'b1;
      bus.dec_jmp = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.imem_ack = 1'b0;
      bus.dec_jmp = 1'b0;
      check("late_retire", bus.retire, 1'b0);
      check("late_req", bus.imem_req, 1'b0);
      @(posedge clk); @(negedge clk);
      check("late_pc", bus.cur_pc, 8'd0);
      check("late_cnt", bus.instr_count, 16'd0);
      check("late_halted", bus.halted, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Fetch/execute controller for the 8-bit Redux-V program counter. It owns the PC register, runs the fetch handshake with instruction memory and latches the decoded control-flow class of each instruction. During the execute cycle it drives the jmx/bmx selects of next_pc and loads next_pc's result into the PC. It sits between instruction memory, the decoder and the next_pc datapath.

Parameters:
PC_W, 8, PC and address width; must match next_pc.
RESET_PC, 0, PC value loaded on reset.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  level; leaves IDLE or HALT and begins fetching.
imem_req  out  1  fetch request; high only in FETCH.
imem_addr  out  PC_W  fetch address; always equals cur_pc.
imem_ack  in  1  memory has the instruction; decode inputs are valid in this cycle.
dec_jmp  in  1  unconditional PC-relative jump.
dec_brz  in  1  PC-relative branch, taken when zero=1.
dec_jr  in  1  register jump to Rb.
dec_halt  in  1  halt instruction.
zero  in  1  ALU zero flag, sampled in EXEC.
jmx  out  1  to next_pc: select curPC+imm.
bmx  out  1  to next_pc: select Rb.
pc_next  in  PC_W  pc output of next_pc.
cur_pc  out  PC_W  PC register; drives next_pc curPC.
retire  out  1  one-cycle pulse in each EXEC cycle.
halted  out  1  high while in HALT.
instr_count  out  CNT_W  count of retired instructions.

Behaviour:
- States: IDLE, FETCH, EXEC, HALT. All outputs decode from registered state or flags; none is a combinational function of imem_ack.
- Reset: state=IDLE, cur_pc=RESET_PC, decode flags=0, instr_count=0. imem_req, jmx, bmx, retire and halted are all 0. Reset takes priority in every state. A reset during FETCH drops imem_req in the next cycle; a late ack is ignored.
- IDLE: go to FETCH when start=1.
- FETCH: imem_req=1. Wait any number of cycles for imem_ack. On ack, latch dec_jmp, dec_brz, dec_jr and dec_halt, then go to EXEC. Minimum fetch latency is 1 cycle: ack in the same cycle as req is legal.
- EXEC: lasts exactly one cycle.
  - bmx = latched jr.
  - jmx = !jr & (jmp | (brz & zero)).
  - If more than one flag is latched, priority is jr > jmp > brz, so jmx and bmx are never both high.
  - At the end of the cycle: cur_pc <= pc_next, retire=1, and instr_count increments, wrapping modulo 2^CNT_W.
  - Next state is HALT if halt was latched, otherwise FETCH.
- PC arithmetic is done by next_pc and is modulo 2^PC_W: 0 + (-4) gives 252, and 255 + 1 gives 0. The sequencer does no arithmetic on the PC.
- HALT: halted=1. The halt instruction retires and the PC advances by +1. While start=0 the block stays in HALT. When start=1 it goes to FETCH at cur_pc.
- Outside EXEC: jmx=bmx=0 and cur_pc holds.
- Instructions per retire: 2 cycles minimum (FETCH then EXEC).

Optional Feature:
Macro SINGLE_STEP_EN.
- When defined, the block adds input step_mode (1 bit). With step_mode=1, every EXEC goes to HALT instead of FETCH. Each start pulse then retires exactly one instruction. halted rises for the step halt as well as for dec_halt.
- When not defined, the port does not exist and behaviour is exactly as specified above.

Test Plan:
- Sequential run: reset with RESET_PC=0, start=1, memory acks 1 cycle after req, no decode flags, 3 instructions -> imem_addr 0, 1, 2; cur_pc=3; instr_count=3; jmx and bmx always 0.
- Relative jump: cur_pc=120, dec_jmp=1, next_pc imm=6 -> jmx=1 only in the EXEC cycle; cur_pc=126; the next fetch is at 126.
- Conditional branch:
  - cur_pc=0, dec_brz=1, imm=-4, zero=0 -> cur_pc=1.
  - Same case with zero=1 -> jmx=1, cur_pc=252 (wrap).
- Register jump and priority: dec_jr=1 with dec_jmp=1 and Rb=55 -> bmx=1, jmx=0, cur_pc=55.
- Halt and stall: a 5-cycle ack delay keeps imem_req high with cur_pc stable. dec_halt at pc 10 -> halted=1, cur_pc=11, no imem_req while start=0. start=1 -> fetch at 11.
- Reset mid-fetch: assert rst during FETCH at pc 40 -> next cycle imem_req=0, cur_pc=0, instr_count=0, state IDLE. An ack that arrives late has no effect.
